// File: rtl/uart_loader_pkg.sv
// Loader frame constants and FSM state encoding.
// Shared by the frame decoder and its timeout counter.
package uart_loader_pkg;

  localparam logic [7:0] LDR_SYNC      = 8'hA5;
  localparam logic [7:0] LDR_CMD_WR    = 8'h01;
  localparam logic [7:0] LDR_CMD_START = 8'h02;
  localparam int         LDR_FRAME_LEN = 9;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    CHK,
    HOLD
  } ldr_state_e;

  function automatic logic ldr_op_legal(input logic [7:0] op);
    return (op == LDR_CMD_WR) || (op == LDR_CMD_START);
  endfunction

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte idle counter with a one-cycle expiry flag.
// Expiry fires in the cycle the count would reach TIMEOUT_CYC.
module uart_loader_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] r_cnt;

  // A byte arriving in the expiry cycle takes precedence.
  assign o_expire = i_en && !i_clr &&
                    (r_cnt == W'(TIMEOUT_CYC - 1));

  // Count idle cycles while a frame is open; restart on every byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (o_expire) r_cnt <= '0;
      else          r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Serial loader frame decoder: sync, opcode, address, data, XOR check.
// Accepted frames are held on a valid/ready command port.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_start,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic        busy,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  ldr_state_e  r_state;
  logic [7:0]  r_op;
  logic [7:0]  r_chk;
  logic [2:0]  r_idx;
  logic [15:0] r_addr;
  logic [31:0] r_data;
  logic        r_cmd_start;
  logic [15:0] r_cmd_addr;
  logic [31:0] r_cmd_data;
  logic        r_frame_err;
  logic [7:0]  r_err_cnt;

  logic w_active;
  logic w_expire;
  logic w_chk_ok;
  logic w_err_evt;

  assign w_active = (r_state == CMD)  || (r_state == ADDR) ||
                    (r_state == DATA) || (r_state == CHK);
  assign w_chk_ok = (rx_byte == r_chk) && ldr_op_legal(r_op);

  uart_loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (received),
    .i_en    (w_active),
    .o_expire(w_expire)
  );

  // Every condition that rejects a frame or drops a byte.
  always_comb begin
    w_err_evt = 1'b0;
    if (r_state == HOLD) begin
      w_err_evt = received;
    end else if (w_active) begin
      if (recv_error)
        w_err_evt = 1'b1;
      else if (received)
        w_err_evt = (r_state == CHK) && !w_chk_ok;
      else
        w_err_evt = w_expire;
    end
  end

  // Frame FSM, assembly registers, checksum and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_chk       <= '0;
      r_idx       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cmd_start <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_data  <= '0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_err_evt;
      if (w_err_evt && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
      unique case (r_state)
        IDLE: begin
          if (received && (rx_byte == LDR_SYNC)) begin
            r_chk   <= '0;
            r_state <= CMD;
          end
        end
        CMD: begin
          if (w_err_evt) begin
            r_state <= IDLE;
          end else if (received) begin
            r_op    <= rx_byte;
            r_chk   <= r_chk ^ rx_byte;
            r_idx   <= '0;
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (w_err_evt) begin
            r_state <= IDLE;
          end else if (received) begin
            r_addr <= {rx_byte, r_addr[15:8]};
            r_chk  <= r_chk ^ rx_byte;
            if (r_idx == 3'd1) begin
              r_idx   <= '0;
              r_state <= DATA;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        DATA: begin
          if (w_err_evt) begin
            r_state <= IDLE;
          end else if (received) begin
            r_data <= {rx_byte, r_data[31:8]};
            r_chk  <= r_chk ^ rx_byte;
            if (r_idx == 3'd3) begin
              r_idx   <= '0;
              r_state <= CHK;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        CHK: begin
          if (w_err_evt) begin
            r_state <= IDLE;
          end else if (received) begin
            r_cmd_start <= (r_op == LDR_CMD_START);
            r_cmd_addr  <= r_addr;
            r_cmd_data  <= (r_op == LDR_CMD_START) ? '0 : r_data;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (cmd_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign cmd_start = r_cmd_start;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_data  = r_cmd_data;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with a command scoreboard.
// Stimulus queues expected commands; a negedge monitor checks them.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        received = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        recv_error = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic        cmd_start;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        busy;
  logic        frame_err;
  logic [7:0]  err_cnt;

  typedef struct packed {
    logic        start;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   err_seen = 0;
  int   exp_err = 0;

  logic [7:0] WR_F [9] = '{8'hA5, 8'h01, 8'h10, 8'h00,
                           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
  logic [7:0] BAD_F [9] = '{8'hA5, 8'h01, 8'h10, 8'h00,
                            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h34};
  logic [7:0] ST_F [9] = '{8'hA5, 8'h02, 8'h00, 8'h01,
                           8'h00, 8'h00, 8'h00, 8'h00, 8'h03};

  uart_loader #(
    .TIMEOUT_CYC(50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .received  (received),
    .rx_byte   (rx_byte),
    .recv_error(recv_error),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    received = 1'b1;
    rx_byte  = b;
    tick();
    received = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f [9]);
    for (int i = 0; i < 9; i++) begin
      send(f[i]);
      if (i < 8) tick();
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: score every handshake and count error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_seen++;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_start", {31'd0, cmd_start}, {31'd0, mon_e.start});
          check("sb_addr", {16'd0, cmd_addr}, {16'd0, mon_e.addr});
          check("sb_data", cmd_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    reset_dut();
    check("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_start", {31'd0, cmd_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_addr", {16'd0, cmd_addr}, 32'd0);
    check("rst_data", cmd_data, 32'd0);
    check("rst_errcnt", {24'd0, err_cnt}, 32'd0);

    // Write frame, consumer always ready.
    cmd_ready = 1'b1;
    exp_q.push_back('{1'b0, 16'h0010, 32'hDEADBEEF});
    send_frame(WR_F);
    check("wr_valid", {31'd0, cmd_valid}, 32'd1);
    check("wr_addr", {16'd0, cmd_addr}, 32'h10);
    check("wr_data", cmd_data, 32'hDEADBEEF);
    tick();
    check("wr_valid_fall", {31'd0, cmd_valid}, 32'd0);
    check("wr_busy", {31'd0, busy}, 32'd0);
    check("wr_errcnt", {24'd0, err_cnt}, 32'd0);

    // Start frame with consumer stall and a byte dropped in HOLD.
    cmd_ready = 1'b0;
    exp_q.push_back('{1'b1, 16'h0100, 32'h0});
    send_frame(ST_F);
    check("st_valid", {31'd0, cmd_valid}, 32'd1);
    check("st_start", {31'd0, cmd_start}, 32'd1);
    check("st_addr", {16'd0, cmd_addr}, 32'h100);
    check("st_data", cmd_data, 32'd0);
    repeat (5) tick();
    send(8'h55);
    exp_err++;
    check("hold_drop_ferr", {31'd0, frame_err}, 32'd1);
    check("hold_drop_cnt", {24'd0, err_cnt}, 32'd1);
    check("hold_drop_valid", {31'd0, cmd_valid}, 32'd1);
    repeat (13) tick();
    check("stall_valid", {31'd0, cmd_valid}, 32'd1);
    check("stall_addr", {16'd0, cmd_addr}, 32'h100);
    cmd_ready = 1'b1;
    tick();
    check("st_valid_fall", {31'd0, cmd_valid}, 32'd0);
    check("st_busy", {31'd0, busy}, 32'd0);

    // Bad checksum, then a good frame.
    reset_dut();
    send_frame(BAD_F);
    exp_err++;
    check("bad_ferr", {31'd0, frame_err}, 32'd1);
    check("bad_valid", {31'd0, cmd_valid}, 32'd0);
    check("bad_cnt", {24'd0, err_cnt}, 32'd1);
    tick();
    check("bad_ferr_pulse", {31'd0, frame_err}, 32'd0);
    exp_q.push_back('{1'b0, 16'h0010, 32'hDEADBEEF});
    send_frame(WR_F);
    check("after_bad_valid", {31'd0, cmd_valid}, 32'd1);
    tick();

    // Garbage bytes in IDLE are silently ignored.
    send(8'h00);
    tick();
    send(8'hFF);
    tick();
    send(8'h5A);
    check("garbage_busy", {31'd0, busy}, 32'd0);
    check("garbage_ferr", {31'd0, frame_err}, 32'd0);
    tick();
    exp_q.push_back('{1'b0, 16'h0010, 32'hDEADBEEF});
    send_frame(WR_F);
    check("garbage_valid", {31'd0, cmd_valid}, 32'd1);
    tick();
    check("garbage_cnt", {24'd0, err_cnt}, 32'd1);

    // Inter-byte timeout (TIMEOUT_CYC = 50).
    send(8'hA5);
    tick();
    send(8'h01);
    tick();
    send(8'h10);
    exp_err++;
    for (int k = 1; k <= 60; k++) begin
      if (k == 50) begin
        check("to_busy_50", {31'd0, busy}, 32'd1);
        check("to_ferr_50", {31'd0, frame_err}, 32'd0);
      end
      if (k == 51) begin
        check("to_ferr_51", {31'd0, frame_err}, 32'd1);
        check("to_busy_51", {31'd0, busy}, 32'd0);
      end
      if (k == 52) check("to_ferr_52", {31'd0, frame_err}, 32'd0);
      tick();
    end
    check("to_cnt", {24'd0, err_cnt}, 32'd2);
    exp_q.push_back('{1'b0, 16'h0010, 32'hDEADBEEF});
    send_frame(WR_F);
    check("to_after_valid", {31'd0, cmd_valid}, 32'd1);
    tick();

    // Framing error after byte 4.
    send(8'hA5);
    tick();
    send(8'h01);
    tick();
    send(8'h10);
    tick();
    send(8'h00);
    recv_error = 1'b1;
    tick();
    recv_error = 1'b0;
    exp_err++;
    check("rxerr_ferr", {31'd0, frame_err}, 32'd1);
    check("rxerr_busy", {31'd0, busy}, 32'd0);
    check("rxerr_cnt", {24'd0, err_cnt}, 32'd3);

    // Reset mid-frame discards everything without an error pulse.
    send(8'hA5);
    tick();
    send(8'h01);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ferr", {31'd0, frame_err}, 32'd0);
    check("mrst_valid", {31'd0, cmd_valid}, 32'd0);
    check("mrst_addr", {16'd0, cmd_addr}, 32'd0);
    check("mrst_data", cmd_data, 32'd0);
    check("mrst_cnt", {24'd0, err_cnt}, 32'd0);
    exp_q.push_back('{1'b0, 16'h0010, 32'hDEADBEEF});
    send_frame(WR_F);
    check("mrst_after_valid", {31'd0, cmd_valid}, 32'd1);
    repeat (3) tick();

    check("queue_empty", exp_q.size(), 32'd0);
    check("err_pulses", err_seen, exp_err);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
